bt656_tx_ctrl: RTL

Sequencing controller for the BT.656 transmitter. Accepts start/stop/restart commands over a valid/ready handshake and latches the transmitter configuration (interlace, first field, first line). Drives the transmitter's reset and valid inputs. Stops or reconfigures the stream only at a field boundary, taken as entry to vertical blanking. Sits between the host/register block and the transmitter, and monitors the transmitter's V/F outputs.

---
 rtl/bt656_tx_ctrl.sv | 298 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/bt656_tx_ctrl.sv
// -----------------------------------------------------------------------------
// bt656_tx_ctrl
//
// Sequencing controller for a BT.656 transmitter.
//
// The host sends START / STOP / RESTART commands over a valid/ready handshake.
// The block brings the transmitter out of reset, lets it settle, and then
// asserts o_TxValid. STOP and RESTART only take effect at a field boundary,
// which is the rising edge of the transmitter's V output (entry to vertical
// blanking). The transmitter configuration is only changed while the
// transmitter is held in reset.
//
// Optional build macro:
//   BT656_TX_CTRL_WATCHDOG_EN - in RUN, a missing field boundary for
//   TIMEOUT_CYCLES cycles sets o_Error and forces a reset/restart of the
//   transmitter with the current configuration. When it is undefined, only
//   the DRAIN timeout exists.
//
// Ports:
//   i_SysClock       system clock
//   i_ResetN         asynchronous active-low reset
//   i_CmdValid       command valid
//   o_CmdReady       command ready (high in IDLE and RUN)
//   i_CmdOp          0=NOP 1=START 2=STOP 3=RESTART
//   i_CmdInterlace   interlace mode carried by START/RESTART
//   i_CmdFirstField  first field id carried by START/RESTART
//   i_CmdFirstLine   first line carried by START/RESTART
//   i_TxVsignal      transmitter V output
//   i_TxFsignal      transmitter F output
//   o_TxResetN       transmitter reset, active-low
//   o_TxValid        transmitter start/valid
//   o_InterlaceMode  latched configuration to transmitter
//   o_FirstField     latched configuration to transmitter
//   o_FirstLine      latched configuration to transmitter
//   o_Running        high while the stream is running (RUN and DRAIN)
//   o_FieldStrobe    one-cycle pulse per field boundary while running
//   o_FieldCount     fields sent since the last accepted START/RESTART
//   o_Error          sticky timeout flag
// -----------------------------------------------------------------------------
module bt656_tx_ctrl #(
  parameter int SYS_CLOCK      = 50000000,
  parameter int PIXEL_CLOCK    = 12500000,
  parameter int RESET_CYCLES   = 8,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic        i_SysClock,
  input  logic        i_ResetN,
  input  logic        i_CmdValid,
  output logic        o_CmdReady,
  input  logic [1:0]  i_CmdOp,
  input  logic        i_CmdInterlace,
  input  logic        i_CmdFirstField,
  input  logic [15:0] i_CmdFirstLine,
  input  logic        i_TxVsignal,
  input  logic        i_TxFsignal,
  output logic        o_TxResetN,
  output logic        o_TxValid,
  output logic        o_InterlaceMode,
  output logic        o_FirstField,
  output logic [15:0] o_FirstLine,
  output logic        o_Running,
  output logic        o_FieldStrobe,
  output logic [15:0] o_FieldCount,
  output logic        o_Error
);

  // The reset pulse must span at least two pixel clocks so the transmitter,
  // running on the slower clock, is guaranteed to see it.
  if (RESET_CYCLES < (2 * SYS_CLOCK) / PIXEL_CLOCK) begin : g_reset_too_short
    $error("RESET_CYCLES shorter than two pixel clock periods");
  end

  localparam int CNT_W = $clog2(RESET_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESET_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  // Opcode 0 is NOP; it is accepted and ignored everywhere.
  localparam logic [1:0] OP_START   = 2'd1;
  localparam logic [1:0] OP_STOP    = 2'd2;
  localparam logic [1:0] OP_RESTART = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RELEASE,
    ST_RUN,
    ST_DRAIN,
    ST_STOP
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic              pending_restart_q, pending_restart_d;
  logic              sh_interlace_q, sh_interlace_d;
  logic              sh_first_field_q, sh_first_field_d;
  logic [15:0]       sh_first_line_q, sh_first_line_d;
  logic              cfg_interlace_q, cfg_interlace_d;
  logic              cfg_first_field_q, cfg_first_field_d;
  logic [15:0]       cfg_first_line_q, cfg_first_line_d;
  logic [15:0]       field_count_q, field_count_d;
  logic              strobe_q, strobe_d;
  logic              error_q, error_d;
  logic              tx_reset_n_q, tx_reset_n_d;
  logic              tx_valid_q, tx_valid_d;
  logic              running_q, running_d;
  logic              cmd_ready_q, cmd_ready_d;

  logic              v_sync_q, v_prev_q;
  logic              f_sync_q, f_prev_q;
  logic              fb;
  logic              f_toggle_unused;
  logic              cmd_accept;

  // V/F come from the transmitter; one register stage, then edge detect.
  assign fb              = v_sync_q & ~v_prev_q;
  // F toggles mark field parity changes; sequencing keys on V only.
  assign f_toggle_unused = f_sync_q ^ f_prev_q;
  assign cmd_accept      = i_CmdValid & cmd_ready_q;

  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    to_d              = to_q;
    pending_restart_d = pending_restart_q;
    sh_interlace_d    = sh_interlace_q;
    sh_first_field_d  = sh_first_field_q;
    sh_first_line_d   = sh_first_line_q;
    cfg_interlace_d   = cfg_interlace_q;
    cfg_first_field_d = cfg_first_field_q;
    cfg_first_line_d  = cfg_first_line_q;
    field_count_d     = field_count_q;
    strobe_d          = 1'b0;
    error_d           = error_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_accept && (i_CmdOp == OP_START || i_CmdOp == OP_RESTART)) begin
          cfg_interlace_d   = i_CmdInterlace;
          cfg_first_field_d = i_CmdFirstField;
          cfg_first_line_d  = i_CmdFirstLine;
          field_count_d     = '0;
          error_d           = 1'b0;
          pending_restart_d = 1'b0;
          cnt_d             = '0;
          state_d           = ST_RELEASE;
        end
      end

      ST_RELEASE: begin
        if (cnt_q == CNT_LAST) begin
          to_d    = '0;
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RUN: begin
        if (fb) begin
          strobe_d      = 1'b1;
          field_count_d = field_count_q + 16'd1;
        end
        // A boundary coinciding with the command is counted here; DRAIN then
        // waits for the following boundary.
        if (cmd_accept && i_CmdOp == OP_STOP) begin
          pending_restart_d = 1'b0;
          to_d              = '0;
          state_d           = ST_DRAIN;
        end else if (cmd_accept && i_CmdOp == OP_RESTART) begin
          sh_interlace_d    = i_CmdInterlace;
          sh_first_field_d  = i_CmdFirstField;
          sh_first_line_d   = i_CmdFirstLine;
          pending_restart_d = 1'b1;
          to_d              = '0;
          state_d           = ST_DRAIN;
        end
`ifdef BT656_TX_CTRL_WATCHDOG_EN
        else if (fb) begin
          to_d = '0;
        end else if (to_q == TO_LAST) begin
          // Stream stalled: recycle the transmitter with its current config.
          error_d           = 1'b1;
          sh_interlace_d    = cfg_interlace_q;
          sh_first_field_d  = cfg_first_field_q;
          sh_first_line_d   = cfg_first_line_q;
          pending_restart_d = 1'b1;
          cnt_d             = '0;
          state_d           = ST_STOP;
        end else begin
          to_d = to_q + TO_W'(1);
        end
`endif
      end

      ST_DRAIN: begin
        // A boundary wins over a simultaneous timeout, so no error then.
        if (fb) begin
          strobe_d      = 1'b1;
          field_count_d = field_count_q + 16'd1;
          cnt_d         = '0;
          state_d       = ST_STOP;
        end else if (to_q == TO_LAST) begin
          error_d = 1'b1;
          cnt_d   = '0;
          state_d = ST_STOP;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end

      ST_STOP: begin
        // Swap in the new config one cycle into the reset pulse, so it only
        // ever changes while the transmitter is held in reset.
        if (cnt_q == '0 && pending_restart_q) begin
          cfg_interlace_d   = sh_interlace_q;
          cfg_first_field_d = sh_first_field_q;
          cfg_first_line_d  = sh_first_line_q;
          field_count_d     = '0;
        end
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = pending_restart_q ? ST_RELEASE : ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with state_q.
    tx_reset_n_d = (state_d == ST_RELEASE) || (state_d == ST_RUN) || (state_d == ST_DRAIN);
    tx_valid_d   = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    running_d    = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    cmd_ready_d  = (state_d == ST_IDLE) || (state_d == ST_RUN);
  end

  always_ff @(posedge i_SysClock or negedge i_ResetN) begin
    if (!i_ResetN) begin
      state_q           <= ST_IDLE;
      cnt_q             <= '0;
      to_q              <= '0;
      pending_restart_q <= 1'b0;
      sh_interlace_q    <= 1'b0;
      sh_first_field_q  <= 1'b0;
      sh_first_line_q   <= '0;
      cfg_interlace_q   <= 1'b0;
      cfg_first_field_q <= 1'b0;
      cfg_first_line_q  <= '0;
      field_count_q     <= '0;
      strobe_q          <= 1'b0;
      error_q           <= 1'b0;
      tx_reset_n_q      <= 1'b0;
      tx_valid_q        <= 1'b0;
      running_q         <= 1'b0;
      cmd_ready_q       <= 1'b1;
      v_sync_q          <= 1'b0;
      v_prev_q          <= 1'b0;
      f_sync_q          <= 1'b0;
      f_prev_q          <= 1'b0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      to_q              <= to_d;
      pending_restart_q <= pending_restart_d;
      sh_interlace_q    <= sh_interlace_d;
      sh_first_field_q  <= sh_first_field_d;
      sh_first_line_q   <= sh_first_line_d;
      cfg_interlace_q   <= cfg_interlace_d;
      cfg_first_field_q <= cfg_first_field_d;
      cfg_first_line_q  <= cfg_first_line_d;
      field_count_q     <= field_count_d;
      strobe_q          <= strobe_d;
      error_q           <= error_d;
      tx_reset_n_q      <= tx_reset_n_d;
      tx_valid_q        <= tx_valid_d;
      running_q         <= running_d;
      cmd_ready_q       <= cmd_ready_d;
      v_sync_q          <= i_TxVsignal;
      v_prev_q          <= v_sync_q;
      f_sync_q          <= i_TxFsignal;
      f_prev_q          <= f_sync_q;
    end
  end

  assign o_CmdReady      = cmd_ready_q;
  assign o_TxResetN      = tx_reset_n_q;
  assign o_TxValid       = tx_valid_q;
  assign o_InterlaceMode = cfg_interlace_q;
  assign o_FirstField    = cfg_first_field_q;
  assign o_FirstLine     = cfg_first_line_q;
  assign o_Running       = running_q;
  assign o_FieldStrobe   = strobe_q;
  assign o_FieldCount    = field_count_q;
  assign o_Error         = error_q;

endmodule
